// File: rtl/mux16_8_rr_if.sv
// Handshake bundle for the 8-lane round-robin merge stage: eight input lanes
// with per-lane valid/ready, plus one tagged output word with valid/ready.
interface mux16_8_rr_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [WIDTH-1:0] in4;
  logic [WIDTH-1:0] in5;
  logic [WIDTH-1:0] in6;
  logic [WIDTH-1:0] in7;
  logic [WIDTH-1:0] in8;
  logic [7:0]       in_valid;
  logic [7:0]       in_ready;
  logic [WIDTH-1:0] out;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       xfer_cnt;

  // Upstream senders and the downstream sink together form the master side.
  modport master (
    output in1, in2, in3, in4, in5, in6, in7, in8,
    output in_valid, out_ready,
    input  in_ready, out, sel, out_valid, xfer_cnt
  );

  modport slave (
    input  in1, in2, in3, in4, in5, in6, in7, in8,
    input  in_valid, out_ready,
    output in_ready, out, sel, out_valid, xfer_cnt
  );
endinterface

// File: rtl/mux16_8_rr.sv
// Registered 8-to-1 merge with round-robin grant; the output register is a
// single-entry skid-free stage that drains and reloads in the same cycle.
module mux16_8_rr #(
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         rst_n,
  mux16_8_rr_if.slave bus
);

  logic [WIDTH-1:0] lane [8];

  assign lane[0] = bus.in1;
  assign lane[1] = bus.in2;
  assign lane[2] = bus.in3;
  assign lane[3] = bus.in4;
  assign lane[4] = bus.in5;
  assign lane[5] = bus.in6;
  assign lane[6] = bus.in7;
  assign lane[7] = bus.in8;

  logic [WIDTH-1:0] out_q, out_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [2:0] grant;
  logic [2:0] idx;
  logic       any_valid;
  logic       load;

  // The lane closest to ptr_q (scanning upward, wrapping) wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    any_valid = 1'b0;
    grant     = ptr_q;
    idx       = ptr_q;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!any_valid && bus.in_valid[idx]) begin
        any_valid = 1'b1;
        grant     = idx;
      end
    end
  end

  assign load         = rst_n && (!out_valid_q || bus.out_ready);
  assign bus.in_ready = (load && any_valid) ? (8'b1 << grant) : 8'h00;

  always_comb begin
    out_d       = out_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q + 8'(out_valid_q && bus.out_ready);
    if (load) begin
      if (any_valid) begin
        out_d       = lane[grant];
        sel_d       = grant;
        out_valid_d = 1'b1;
        ptr_d       = grant + 3'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_mux16_8_rr.sv
// Bench for mux16_8_rr: directed scenarios plus a randomized run checked
// against a behavioural model of the merge stage.
module tb_mux16_8_rr;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] lane_d [8];

  mux16_8_rr_if #(.WIDTH(16)) bus ();

  mux16_8_rr #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.in1 = lane_d[0];
  assign bus.in2 = lane_d[1];
  assign bus.in3 = lane_d[2];
  assign bus.in4 = lane_d[3];
  assign bus.in5 = lane_d[4];
  assign bus.in6 = lane_d[5];
  assign bus.in7 = lane_d[6];
  assign bus.in8 = lane_d[7];

  // Behavioural model state.
  int          m_ptr;
  logic [15:0] m_out;
  int          m_sel;
  bit          m_ov;
  int          m_cnt;

  function automatic int model_grant();
    for (int k = 0; k < 8; k++)
      if (bus.in_valid[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
    return -1;
  endfunction

  function automatic logic [7:0] model_ready();
    int g;
    g = model_grant();
    if (rst_n && (!m_ov || bus.out_ready) && g >= 0) return 8'(1 << g);
    return 8'h00;
  endfunction

  // Advance the model from the pre-edge inputs, then cross one clock edge.
  task automatic tick();
    int g;
    bit ld;
    g  = model_grant();
    ld = rst_n && (!m_ov || bus.out_ready);
    if (!rst_n) begin
      m_ptr = 0; m_out = '0; m_sel = 0; m_ov = 0; m_cnt = 0;
    end else begin
      if (m_ov && bus.out_ready) m_cnt = (m_cnt + 1) % 256;
      if (ld) begin
        if (g >= 0) begin
          m_out = lane_d[g]; m_sel = g; m_ov = 1; m_ptr = (g + 1) % 8;
        end else begin
          m_ov = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 8'hFF; bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) lane_d[i] = 16'(i + 1);
    #1;
    tick();
    tick();
    total++;
    if (bus.in_ready !== 8'h00) begin
      bad++; $display("FAIL reset_in_ready got=%h want=00", bus.in_ready);
    end
    total++;
    if (bus.out_valid !== 1'b0 || bus.out !== 16'h0000 || bus.sel !== 3'd0) begin
      bad++; $display("FAIL reset_out got v=%b out=%h sel=%0d want v=0 out=0000 sel=0",
                      bus.out_valid, bus.out, bus.sel);
    end
    total++;
    if (bus.xfer_cnt !== 8'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d want=0", bus.xfer_cnt);
    end
    rst_n = 1'b1; bus.in_valid = 8'h00;
    tick();
  endtask

  task automatic test_single_lane();
    bus.in_valid = 8'h08; lane_d[3] = 16'hA5A5; bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 8'h08) begin
      bad++; $display("FAIL single_ready got=%h want=08", bus.in_ready);
    end
    tick();
    bus.in_valid = 8'h00;
    total++;
    if (bus.out !== 16'hA5A5 || bus.sel !== 3'd3 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL single_out got out=%h sel=%0d v=%b want out=a5a5 sel=3 v=1",
                      bus.out, bus.sel, bus.out_valid);
    end
    tick();
    total++;
    if (bus.xfer_cnt !== 8'd1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL single_cnt got cnt=%0d v=%b want cnt=1 v=0",
                      bus.xfer_cnt, bus.out_valid);
    end
  endtask

  task automatic test_round_robin();
    int c0;
    // Grant lane 7 first so the pointer wraps to 0.
    bus.in_valid = 8'h80;
    tick();
    c0 = int'(bus.xfer_cnt);
    for (int k = 0; k < 8; k++) lane_d[k] = 16'(16'h1111 * (k + 1));
    bus.in_valid = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      total++;
      if (bus.sel !== 3'(i % 8) || bus.out !== 16'(16'h1111 * (i % 8 + 1))) begin
        bad++; $display("FAIL rr_step%0d got sel=%0d out=%h want sel=%0d out=%h", i,
                        bus.sel, bus.out, i % 8, 16'(16'h1111 * (i % 8 + 1)));
      end
      total++;
      if (bus.xfer_cnt !== 8'(c0 + i + 1)) begin
        bad++; $display("FAIL rr_cnt%0d got=%0d want=%0d", i, bus.xfer_cnt, c0 + i + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] c0;
    tick();
    total++;
    if (bus.out !== 16'h2222 || bus.sel !== 3'd1 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_setup got out=%h sel=%0d v=%b want out=2222 sel=1 v=1",
                      bus.out, bus.sel, bus.out_valid);
    end
    c0 = bus.xfer_cnt;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (bus.in_ready !== 8'h00) begin
        bad++; $display("FAIL bp_ready%0d got=%h want=00", i, bus.in_ready);
      end
      tick();
      total++;
      if (bus.out !== 16'h2222 || bus.sel !== 3'd1 || bus.xfer_cnt !== c0) begin
        bad++; $display("FAIL bp_hold%0d got out=%h sel=%0d cnt=%0d want out=2222 sel=1 cnt=%0d",
                        i, bus.out, bus.sel, bus.xfer_cnt, c0);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 8'h04) begin
      bad++; $display("FAIL bp_release_ready got=%h want=04", bus.in_ready);
    end
    tick();
    total++;
    if (bus.sel !== 3'd2) begin
      bad++; $display("FAIL bp_release_sel got=%0d want=2", bus.sel);
    end
  endtask

  task automatic test_pointer_wrap();
    bus.in_valid = 8'h40;
    tick();
    total++;
    if (bus.sel !== 3'd6) begin
      bad++; $display("FAIL wrap_setup got sel=%0d want=6", bus.sel);
    end
    bus.in_valid = 8'h41;
    tick();
    total++;
    if (bus.sel !== 3'd0) begin
      bad++; $display("FAIL wrap_first got sel=%0d want=0", bus.sel);
    end
    tick();
    total++;
    if (bus.sel !== 3'd6) begin
      bad++; $display("FAIL wrap_second got sel=%0d want=6", bus.sel);
    end
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 8'h10;
    tick();
    total++;
    if (bus.sel !== 3'd4 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL rmid_setup got sel=%0d v=%b want sel=4 v=1", bus.sel, bus.out_valid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.xfer_cnt !== 8'd0) begin
      bad++; $display("FAIL rmid_clear got v=%b cnt=%0d want v=0 cnt=0", bus.out_valid, bus.xfer_cnt);
    end
    bus.in_valid = 8'h81;
    #1;
    total++;
    if (bus.in_ready !== 8'h01) begin
      bad++; $display("FAIL rmid_ready got=%h want=01", bus.in_ready);
    end
    tick();
    total++;
    if (bus.sel !== 3'd0) begin
      bad++; $display("FAIL rmid_sel got=%0d want=0", bus.sel);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_r;
    for (int n = 0; n < 400; n++) begin
      rst_n         = ($urandom_range(0, 40) != 0);
      bus.in_valid  = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 8; k++) lane_d[k] = 16'($urandom);
      #1;
      exp_r = model_ready();
      total++;
      if (bus.in_ready !== exp_r) begin
        bad++; $display("FAIL rand_ready@%0d got=%h want=%h", n, bus.in_ready, exp_r);
      end
      tick();
      total++;
      if (bus.out_valid !== m_ov || bus.xfer_cnt !== 8'(m_cnt) ||
          bus.out !== m_out || bus.sel !== 3'(m_sel)) begin
        bad++; $display("FAIL rand_state@%0d got v=%b out=%h sel=%0d cnt=%0d want v=%b out=%h sel=%0d cnt=%0d",
                        n, bus.out_valid, bus.out, bus.sel, bus.xfer_cnt,
                        m_ov, m_out, m_sel, m_cnt);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    m_ptr = 0; m_out = '0; m_sel = 0; m_ov = 0; m_cnt = 0;
    test_reset();
    test_single_lane();
    test_round_robin();
    test_backpressure();
    test_pointer_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux16_8_rr.md
# mux16_8_rr

Registered 8-to-1 16-bit merge stage with round-robin arbitration and valid/ready handshakes. It is the collecting counterpart of `dmux16_8`: it funnels eight 16-bit lanes onto one output word. The 3-bit output `sel` tags each word with its source lane, so a downstream `dmux16_8` can route it back. The output is held in a single-entry register that stalls cleanly under backpressure.

## Interface
- `WIDTH`, 16, data width of every lane and of `out`.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in1` … `in8`  in  WIDTH  lane data. Lane *k* is index *k*−1.
- `in_valid`  in  8  per-lane valid; bit *i* belongs to lane *i*+1.
- `in_ready`  out  8  per-lane ready (combinational); bit *i* = lane *i*+1 accepted this cycle.
- `out`  out  WIDTH  registered output data.
- `sel`  out  3  registered source-lane index of `out` (0 = `in1` … 7 = `in8`).
- `out_valid`  out  1  `out`/`sel` hold a word.
- `out_ready`  in  1  downstream accepts the word.
- `xfer_cnt`  out  8  count of completed output handshakes; wraps 255→0.

## Operation
- **Input handshake.** A lane transfer occurs when `in_valid[i] && in_ready[i]` at a rising edge. Senders hold data and valid stable until accepted. `in_ready` may depend on `in_valid`; `in_valid` must not depend on `in_ready`.
- **Load enable.** `load = rst_n && (!out_valid || out_ready)`.
- **Grant.** `g` is the first lane with `in_valid` set, scanning upward from priority pointer `ptr` (3 bits) and wrapping 7→0.
  - `in_ready` is one-hot at bit `g` when `load` is high and any valid is set; otherwise it is 8'h00.
  - At most one `in_ready` bit is ever high.
- **On `load` with a grant:**
  - `out` ← lane `g` data
  - `sel` ← `g`
  - `out_valid` ← 1
  - `ptr` ← (`g`+1) mod 8
- **On `load` with no valid lane:** `out_valid` ← 0. `out`, `sel` and `ptr` keep their values.
- **When `load` is low:** all registers hold and `in_ready` is 8'h00.
- **Counter.** `xfer_cnt` increments by 1 on each edge where `out_valid && out_ready` (mod 256).
- **Simultaneous drain and reload.** Allowed in the same cycle: the old word leaves and the new one loads, with no bubble.
- **Reset value** (`rst_n` low at an edge): `out`=0, `sel`=0, `out_valid`=0, `ptr`=0, `xfer_cnt`=0.
  - `in_ready` is forced to 8'h00 while `rst_n` is low.
  - A word held at reset is discarded and is not counted.

## Timing
- Latency: 1 cycle from the input handshake edge to `out_valid`/`out` visible.
- Throughput: 1 word per cycle while `out_ready` stays high and any lane is valid.
- Fairness: with all lanes continuously valid, each lane is granted exactly once in every 8 consecutive grants.
- `out`, `sel` and `out_valid` are stable whenever `out_valid && !out_ready`.
- `in_ready` is purely combinational from `rst_n`, `out_valid`, `out_ready`, `in_valid` and `ptr`. There is no register in that path.

## Test plan
1. **Reset.** `rst_n`=0 for 2 cycles with `in_valid`=8'hFF and `out_ready`=1.
   - Required: `in_ready`=8'h00, `out_valid`=0, `out`=16'h0000, `sel`=0, `xfer_cnt`=0.
2. **Single lane.** After reset, `in_valid`=8'h08, `in4`=16'hA5A5, `out_ready`=1.
   - Same cycle: `in_ready`=8'h08.
   - Next cycle: `out`=16'hA5A5, `sel`=3, `out_valid`=1.
   - Following edge: `xfer_cnt`=1.
3. **Round robin.** `in_valid`=8'hFF, `in`*k*=16'h1111×*k*, `out_ready` held at 1 for 9 cycles.
   - Required: `sel` sequence 0,1,2,3,4,5,6,7,0; `out` sequence 16'h1111 … 16'h8888, 16'h1111.
   - `xfer_cnt` advances by 1 each cycle.
4. **Backpressure.** With `out_valid`=1, `out`=16'h2222, `sel`=1, drive `out_ready`=0 for 3 cycles while `in_valid`=8'hFF.
   - During the stall: `in_ready`=8'h00, `out` and `sel` unchanged, `xfer_cnt` unchanged.
   - Raise `out_ready`: in that same cycle `in_ready`=8'h04; next cycle `sel`=2.
5. **Pointer wrap.** Grant lane 6 (`sel`=6, `ptr`=7), then hold `in_valid`=8'h41.
   - Required: next grant is lane 0 (`sel`=0), then lane 6 (`sel`=6).
6. **Reset mid-operation.** While `out_valid`=1 and `ptr`=5, pulse `rst_n`=0 for 1 cycle.
   - Required: `out_valid`=0 and `xfer_cnt`=0 after the edge.
   - Then `in_valid`=8'h81: lane 0 is granted first (`sel`=0), confirming `ptr` reset to 0.
